// File: rtl/bm_stmt_case_unpack.sv
// bm_stmt_case_unpack
//   Decodes complemented code nibbles (data = ~code) and assembles groups of
//   WORD_NIB decoded nibbles into one word, most significant nibble first.
//   A word always begins with a nibble flagged by start_in. A nibble that
//   arrives without start_in while no word is open is still decoded, but it
//   is not collected and it raises err_out. A start_in in the middle of a
//   word also raises err_out: the partial word is dropped and a new word
//   begins with that nibble.
//
// Ports
//   clock      in   single clock, rising edge
//   reset      in   asynchronous, active-high
//   code_in    in   [BITS-1:0] complemented code nibble
//   code_valid in   code_in is accepted on this edge
//   start_in   in   accepted nibble is the first (MSB) nibble of a word
//   dec_out    out  [BITS-1:0] decoded value of the last accepted code
//   dec_valid  out  one-cycle pulse after each accepted code
//   word_out   out  [BITS*WORD_NIB-1:0] last completed word
//   word_valid out  one-cycle pulse when word_out updates
//   nib_cnt    out  [1:0] number of nibbles collected in the current word
//   err_out    out  one-cycle pulse on a framing error
//
// State table
//   IDLE    | no word open; a start nibble opens one
//   COLLECT | word open, nib_cnt nibbles held in shift_q
//   DONE    | one cycle: publish shift_q on word_out; also accepts input as IDLE

module bm_stmt_case_unpack #(
  parameter int BITS     = 4,
  parameter int WORD_NIB = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [BITS-1:0]          code_in,
  input  logic                     code_valid,
  input  logic                     start_in,
  output logic [BITS-1:0]          dec_out,
  output logic                     dec_valid,
  output logic [BITS*WORD_NIB-1:0] word_out,
  output logic                     word_valid,
  output logic [1:0]               nib_cnt,
  output logic                     err_out
);

  localparam int WORD_W = BITS * WORD_NIB;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [1:0]        nib_cnt_q, nib_cnt_d;
  logic [BITS-1:0]   dec_q, dec_d;
  logic              dec_valid_q, dec_valid_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic              err_q, err_d;
  logic [BITS-1:0]   dec_nib;

  function automatic logic [BITS-1:0] decode(input logic [BITS-1:0] c);
    logic [BITS-1:0] d;
    case (c)
      4'h0:    d = 4'hF;
      4'h1:    d = 4'hE;
      4'h2:    d = 4'hD;
      4'h3:    d = 4'hC;
      4'h4:    d = 4'hB;
      4'h5:    d = 4'hA;
      4'h6:    d = 4'h9;
      4'h7:    d = 4'h8;
      4'h8:    d = 4'h7;
      4'h9:    d = 4'h6;
      4'hA:    d = 4'h5;
      4'hB:    d = 4'h4;
      4'hC:    d = 4'h3;
      4'hD:    d = 4'h2;
      4'hE:    d = 4'h1;
      4'hF:    d = 4'h0;
      default: d = '0;
    endcase
    return d;
  endfunction

  assign dec_nib = decode(code_in);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    nib_cnt_d    = nib_cnt_q;
    dec_d        = dec_q;
    dec_valid_d  = 1'b0;
    word_d       = word_q;
    word_valid_d = 1'b0;
    err_d        = 1'b0;

    // DONE publishes the word regardless of what arrives in the same cycle;
    // word_d samples shift_q before any new nibble overwrites it.
    if (state_q == DONE) begin
      word_d       = shift_q;
      word_valid_d = 1'b1;
      state_d      = IDLE;
    end

    if (code_valid) begin
      dec_d       = dec_nib;
      dec_valid_d = 1'b1;
      case (state_q)
        COLLECT: begin
          if (start_in) begin
            err_d     = 1'b1;
            shift_d   = {dec_nib, {(WORD_W-BITS){1'b0}}};
            nib_cnt_d = 2'd1;
          end else begin
            case (nib_cnt_q)
              2'd1:    shift_d[2*BITS +: BITS] = dec_nib;
              2'd2:    shift_d[BITS +: BITS]   = dec_nib;
              2'd3:    shift_d[0 +: BITS]      = dec_nib;
              default: shift_d[3*BITS +: BITS] = dec_nib;
            endcase
            if (nib_cnt_q == 2'd3) begin
              nib_cnt_d = 2'd0;
              state_d   = DONE;
            end else begin
              nib_cnt_d = nib_cnt_q + 2'd1;
            end
          end
        end
        default: begin
          // IDLE and DONE treat input identically
          if (start_in) begin
            shift_d   = {dec_nib, {(WORD_W-BITS){1'b0}}};
            nib_cnt_d = 2'd1;
            state_d   = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (state_q != IDLE && state_q != COLLECT && state_q != DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      nib_cnt_q    <= 2'd0;
      dec_q        <= '0;
      dec_valid_q  <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      nib_cnt_q    <= nib_cnt_d;
      dec_q        <= dec_d;
      dec_valid_q  <= dec_valid_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
    end
  end

  assign dec_out    = dec_q;
  assign dec_valid  = dec_valid_q;
  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign nib_cnt    = nib_cnt_q;
  assign err_out    = err_q;

endmodule

// File: tb/tb_bm_stmt_case_unpack.sv
module tb_bm_stmt_case_unpack;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  code_in = 4'h0;
  logic        code_valid = 1'b0;
  logic        start_in = 1'b0;
  logic [3:0]  dec_out;
  logic        dec_valid;
  logic [15:0] word_out;
  logic        word_valid;
  logic [1:0]  nib_cnt;
  logic        err_out;

  int n_checks = 0;
  int n_err    = 0;

  bm_stmt_case_unpack #(.BITS(4), .WORD_NIB(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .code_in    (code_in),
    .code_valid (code_valid),
    .start_in   (start_in),
    .dec_out    (dec_out),
    .dec_valid  (dec_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .nib_cnt    (nib_cnt),
    .err_out    (err_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of input, then sample 1 time unit after the edge
  task automatic step(input logic v, input logic s, input logic [3:0] c);
    @(negedge clock);
    code_valid = v;
    start_in   = s;
    code_in    = c;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".dec_out"},    32'(dec_out),    32'h0);
    chk({tag, ".dec_valid"},  32'(dec_valid),  32'h0);
    chk({tag, ".word_out"},   32'(word_out),   32'h0);
    chk({tag, ".word_valid"}, 32'(word_valid), 32'h0);
    chk({tag, ".nib_cnt"},    32'(nib_cnt),    32'h0);
    chk({tag, ".err_out"},    32'(err_out),    32'h0);
  endtask

  initial begin
    // reset state, including an edge while reset is held
    #12;
    chk_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // single decode: 0101 with start -> 1010
    step(1, 1, 4'b0101);
    chk("single.dec_out", 32'(dec_out), 32'hA);
    chk("single.dec_valid", 32'(dec_valid), 32'h1);
    chk("single.nib_cnt", 32'(nib_cnt), 32'h1);
    chk("single.err_out", 32'(err_out), 32'h0);
    step(1, 0, 4'hC);
    step(1, 0, 4'h9);
    step(1, 0, 4'h0);
    chk("single.nib_wrap", 32'(nib_cnt), 32'h0);
    chk("single.wv_early", 32'(word_valid), 32'h0);
    idle(1);
    chk("single.word_valid", 32'(word_valid), 32'h1);
    chk("single.word_out", 32'(word_out), 32'hA36F);

    // full word 1248 back-to-back
    step(1, 1, 4'hE);
    chk("full.wv_drop", 32'(word_valid), 32'h0);
    step(1, 0, 4'hD);
    step(1, 0, 4'hB);
    step(1, 0, 4'h7);
    chk("full.dec_out", 32'(dec_out), 32'h8);
    chk("full.nib_cnt", 32'(nib_cnt), 32'h0);
    chk("full.wv_lat1", 32'(word_valid), 32'h0);
    idle(1);
    chk("full.word_valid", 32'(word_valid), 32'h1);
    chk("full.word_out", 32'(word_out), 32'h1248);
    chk("full.dec_valid_idle", 32'(dec_valid), 32'h0);
    idle(1);
    chk("full.wv_pulse", 32'(word_valid), 32'h0);
    chk("full.word_hold", 32'(word_out), 32'h1248);
    chk("full.dec_hold", 32'(dec_out), 32'h8);

    // restart mid-word
    step(1, 1, 4'hE);
    step(1, 0, 4'hD);
    chk("restart.nib2", 32'(nib_cnt), 32'h2);
    step(1, 1, 4'h0);
    chk("restart.err_out", 32'(err_out), 32'h1);
    chk("restart.nib_cnt", 32'(nib_cnt), 32'h1);
    chk("restart.dec_out", 32'(dec_out), 32'hF);
    step(1, 0, 4'hF);
    chk("restart.err_pulse", 32'(err_out), 32'h0);
    chk("restart.nib_cnt2", 32'(nib_cnt), 32'h2);
    step(1, 0, 4'hF);
    step(1, 0, 4'hF);
    chk("restart.nib_wrap", 32'(nib_cnt), 32'h0);
    idle(1);
    chk("restart.word_valid", 32'(word_valid), 32'h1);
    chk("restart.word_out", 32'(word_out), 32'hF000);

    // stray nibble in IDLE
    step(1, 0, 4'b0011);
    chk("stray.dec_out", 32'(dec_out), 32'hC);
    chk("stray.dec_valid", 32'(dec_valid), 32'h1);
    chk("stray.err_out", 32'(err_out), 32'h1);
    chk("stray.nib_cnt", 32'(nib_cnt), 32'h0);
    chk("stray.word_valid", 32'(word_valid), 32'h0);
    idle(1);
    chk("stray.err_pulse", 32'(err_out), 32'h0);
    chk("stray.word_valid2", 32'(word_valid), 32'h0);
    chk("stray.word_hold", 32'(word_out), 32'hF000);

    // gaps of 3 cycles, then next start in the DONE cycle
    step(1, 1, 4'hA);
    idle(3);
    step(1, 0, 4'h5);
    idle(3);
    chk("gap.nib_hold", 32'(nib_cnt), 32'h2);
    chk("gap.dec_hold", 32'(dec_out), 32'hA);
    step(1, 0, 4'h3);
    idle(3);
    step(1, 0, 4'hC);
    chk("gap.nib_wrap", 32'(nib_cnt), 32'h0);
    step(1, 1, 4'h6);
    chk("gap.word_valid", 32'(word_valid), 32'h1);
    chk("gap.word_out", 32'(word_out), 32'h5AC3);
    chk("gap.done_start_nib", 32'(nib_cnt), 32'h1);
    chk("gap.done_start_err", 32'(err_out), 32'h0);
    step(1, 0, 4'h4);
    step(1, 0, 4'h2);
    step(1, 0, 4'h1);
    idle(1);
    chk("b2b.word_valid", 32'(word_valid), 32'h1);
    chk("b2b.word_out", 32'(word_out), 32'h9BDE);

    // non-start nibble in DONE: word and error together
    step(1, 1, 4'h0);
    step(1, 0, 4'h0);
    step(1, 0, 4'h0);
    step(1, 0, 4'h0);
    step(1, 0, 4'h8);
    chk("donestray.word_valid", 32'(word_valid), 32'h1);
    chk("donestray.word_out", 32'(word_out), 32'hFFFF);
    chk("donestray.err_out", 32'(err_out), 32'h1);
    chk("donestray.dec_out", 32'(dec_out), 32'h7);
    chk("donestray.nib_cnt", 32'(nib_cnt), 32'h0);
    idle(1);
    chk("donestray.wv_pulse", 32'(word_valid), 32'h0);

    // reset mid-word after 3 nibbles
    step(1, 1, 4'hE);
    step(1, 0, 4'hD);
    step(1, 0, 4'hB);
    chk("rstmid.nib3", 32'(nib_cnt), 32'h3);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("rstmid.async");
    code_valid = 1'b1;
    start_in   = 1'b1;
    code_in    = 4'h7;
    @(posedge clock);
    #1;
    chk_all_zero("rstmid.held");
    @(negedge clock);
    reset      = 1'b0;
    code_valid = 1'b0;
    start_in   = 1'b0;
    step(1, 0, 4'h7);
    chk("rstmid.needs_start", 32'(err_out), 32'h1);
    chk("rstmid.nib_cnt", 32'(nib_cnt), 32'h0);
    chk("rstmid.dec_out", 32'(dec_out), 32'h8);
    idle(2);
    chk("rstmid.no_word", 32'(word_valid), 32'h0);
    chk("rstmid.word_out", 32'(word_out), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
